// File: rtl/image_blend_pkg.sv
// Shared mode encodings and width helpers for the image_blend_stream pixel combiner.
package image_blend_pkg;

  typedef enum logic [1:0] {
    MODE_ADD     = 2'd0,
    MODE_ABSDIFF = 2'd1,
    MODE_MAX     = 2'd2,
    MODE_RSVD    = 2'd3
  } blend_mode_t;

  function automatic int prod_width(input int pix_w, input int wgt_w);
    return pix_w + wgt_w;
  endfunction

  function automatic int sum_width(input int pix_w, input int wgt_w);
    return pix_w + wgt_w + 1;
  endfunction

endpackage

// File: rtl/image_blend_stream_join.sv
// Two-stream valid/ready join plus raster position and frame-marker generation.
module pixel_pair_join #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  input  logic s1_ready,
  output logic a_ready,
  output logic b_ready,
  output logic fire,
  output logic sof,
  output logic eol,
  output logic eof
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Each ready depends on the other stream's valid so neither side is consumed alone.
  assign a_ready = b_valid & s1_ready;
  assign b_ready = a_valid & s1_ready;
  assign fire    = a_valid & b_valid & s1_ready;

  assign sof = (col == '0) && (row == '0);
  assign eol = (col == COL_W'(IMG_W - 1));
  assign eof = eol && (row == ROW_W'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (fire) begin
      if (eol) begin
        col <= '0;
        row <= eof ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_blend_stream.sv
// Streaming two-image weighted pixel combiner with frame markers.
// Optional per-frame clip counter enabled by defining IMG_BLEND_CLIP_CNT_EN.
module image_blend_stream
  import image_blend_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int WGT_W = 8,
  parameter int SHIFT = 6,
  parameter int OFS_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [PIX_W-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [PIX_W-1:0] b_data,
  output logic             b_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [WGT_W-1:0] cfg_wa,
  input  logic [WGT_W-1:0] cfg_wb,
  input  logic [OFS_W-1:0] cfg_offset,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_data,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             frame_done,
  output logic [CNT_W-1:0] clip_count
);

  localparam int PROD_W = prod_width(PIX_W, WGT_W);
  localparam int SUM_W  = sum_width(PIX_W, WGT_W);
  localparam logic [SUM_W:0] RND_HALF = (SUM_W + 1)'(1) << (SHIFT - 1);
  localparam logic signed [SUM_W+1:0] PIX_MAX_V = (SUM_W + 2)'((1 << PIX_W) - 1);

  logic s1_valid, s1_ready, s2_ready;
  logic join_fire, pos_sof, pos_eol, pos_eof;

  assign s2_ready = !out_valid | out_ready;
  assign s1_ready = !s1_valid | s2_ready;

  pixel_pair_join #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_join (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .b_valid  (b_valid),
    .s1_ready (s1_ready),
    .a_ready  (a_ready),
    .b_ready  (b_ready),
    .fire     (join_fire),
    .sof      (pos_sof),
    .eol      (pos_eol),
    .eof      (pos_eof)
  );

  blend_mode_t      mode_q, mode_e;
  logic [WGT_W-1:0] wa_q, wb_q, wa_e, wb_e;
  logic [OFS_W-1:0] ofs_q, ofs_e;

  // Pixel (0,0) uses the live config directly; the rest of the frame uses the latched copy.
  assign mode_e = pos_sof ? blend_mode_t'(cfg_mode) : mode_q;
  assign wa_e   = pos_sof ? cfg_wa     : wa_q;
  assign wb_e   = pos_sof ? cfg_wb     : wb_q;
  assign ofs_e  = pos_sof ? cfg_offset : ofs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_ADD;
      wa_q   <= '0;
      wb_q   <= '0;
      ofs_q  <= '0;
    end else if (join_fire && pos_sof) begin
      mode_q <= blend_mode_t'(cfg_mode);
      wa_q   <= cfg_wa;
      wb_q   <= cfg_wb;
      ofs_q  <= cfg_offset;
    end
  end

  logic [PROD_W-1:0] prod_a, prod_b;
  logic [PIX_W-1:0]  pix_max;
  logic [SUM_W-1:0]  sum_d;

  always_comb begin
    prod_a  = PROD_W'(a_data) * PROD_W'(wa_e);
    prod_b  = PROD_W'(b_data) * PROD_W'(wb_e);
    pix_max = (a_data > b_data) ? a_data : b_data;
    sum_d   = SUM_W'(prod_a) + SUM_W'(prod_b);
    case (mode_e)
      MODE_ABSDIFF: sum_d = (prod_a >= prod_b) ? SUM_W'(prod_a - prod_b) : SUM_W'(prod_b - prod_a);
      MODE_MAX:     sum_d = SUM_W'(pix_max) << SHIFT;
      default:      sum_d = SUM_W'(prod_a) + SUM_W'(prod_b);
    endcase
  end

  logic [SUM_W-1:0] s1_sum;
  logic [OFS_W-1:0] s1_ofs;
  logic             s1_sof, s1_eol, s1_eof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_ofs   <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= join_fire;
      if (join_fire) begin
        s1_sum <= sum_d;
        s1_ofs <= ofs_e;
        s1_sof <= pos_sof;
        s1_eol <= pos_eol;
        s1_eof <= pos_eof;
      end
    end
  end

  logic [SUM_W:0]          rounded;
  logic signed [SUM_W+1:0] v;
  logic                    clip_lo, clip_hi;
  logic [PIX_W-1:0]        pix_d;

  always_comb begin
    rounded = ({1'b0, s1_sum} + RND_HALF) >> SHIFT;
    v       = $signed({1'b0, rounded}) - $signed({{(SUM_W + 2 - OFS_W){s1_ofs[OFS_W-1]}}, s1_ofs});
    clip_lo = v[SUM_W+1];
    clip_hi = !clip_lo && (v > PIX_MAX_V);
    pix_d   = v[PIX_W-1:0];
    if (clip_lo) pix_d = '0;
    else if (clip_hi) pix_d = '1;
  end

  logic s2_load, eof_xfer;
  assign s2_load  = s2_ready & s1_valid;
  assign eof_xfer = out_valid & out_ready & out_eof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= eof_xfer;
      if (s2_ready) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= pix_d;
          out_sof  <= s1_sof;
          out_eol  <= s1_eol;
          out_eof  <= s1_eof;
        end
      end
    end
  end

`ifdef IMG_BLEND_CLIP_CNT_EN
  logic [CNT_W-1:0] clip_cnt, clip_base;

  // A clip from the next frame's first pixel may land in S2 on the same edge the eof leaves.
  assign clip_base = eof_xfer ? '0 : clip_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_cnt   <= '0;
      clip_count <= '0;
    end else begin
      if (eof_xfer) clip_count <= clip_cnt;
      if (s2_load && (clip_lo || clip_hi) && (clip_base != '1))
        clip_cnt <= clip_base + 1'b1;
      else
        clip_cnt <= clip_base;
    end
  end
`else
  assign clip_count = '0;
`endif

endmodule
